// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, addresses instruction memory port a and
// presents each returned word with its byte PC to decode. Supports stall and branch redirect.
module instr_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  mem_we,
    input  logic                  stall,
    input  logic                  branch_en,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [31:0]           fetch_count
);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [31:0]           fetch_count_q, fetch_count_d;
    logic                  advance;

    // Bubbles are never held: stall only matters while an instruction is on the output.
    assign advance = !stall || !resp_valid_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        resp_valid_d  = resp_valid_q;
        hold_instr_d  = hold_instr_q;
        hold_valid_d  = hold_valid_q;
        fetch_count_d = fetch_count_q;
        if (branch_en) begin
            fetch_pc_d   = branch_target & ~DATA_WIDTH'(3);
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (advance) begin
            resp_pc_d    = fetch_pc_q;
            resp_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + DATA_WIDTH'(4);
            hold_valid_d = 1'b0;
            if (resp_valid_q) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end else if (!hold_valid_q) begin
            // First stalled edge: mem_q still belongs to resp_pc, so capture it before it moves on.
            hold_instr_d = mem_q;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= '0;
            resp_valid_q  <= 1'b0;
            hold_instr_q  <= '0;
            hold_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            resp_valid_q  <= resp_valid_d;
            hold_instr_q  <= hold_instr_d;
            hold_valid_q  <= hold_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign mem_addr    = fetch_pc_q[ADDR_WIDTH+1:2];
    assign mem_we      = 1'b0;
    assign instr       = hold_valid_q ? hold_instr_q : mem_q;
    assign instr_pc    = resp_pc_q;
    assign instr_valid = resp_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: synchronous-read memory model, abstract PC-stream
// reference model with per-cycle compare, plus directed literal checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mem_addr;
    logic [31:0] mem_q;
    logic        mem_we;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram [4096];

    instr_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_q(mem_q), .mem_we(mem_we),
        .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA500_0000 | i;
        mem_q = '0;
    end

    always @(posedge clk) mem_q <= ram[mem_addr];

    // Reference model: the stream of presented PCs, the next PC to present and the accept count.
    bit          chk_en = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_npc = '0;
    logic [31:0] m_count = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_pc = '0; m_npc = 32'h0; m_count = '0; chk_en = 1'b1;
        end else if (branch_en) begin
            m_valid = 1'b0;
            m_npc = {branch_target[31:2], 2'b00};
        end else if (!stall || !m_valid) begin
            if (m_valid) m_count = m_count + 1;
            m_valid = 1'b1;
            m_pc = m_npc;
            m_npc = m_npc + 4;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            check("m_count", fetch_count, m_count);
            check("m_we", {31'b0, mem_we}, 32'h0);
            check("m_addr", {20'b0, mem_addr}, {20'b0, m_npc[13:2]});
            if (m_valid) begin
                check("m_pc", instr_pc, m_pc);
                check("m_instr", instr, ram[m_pc[13:2]]);
            end
        end
    end

    // Inputs change just after the falling edge; outputs seen here reflect the previous rising edge.
    task automatic cyc(input logic r, input logic st, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        #1;
        rst = r; stall = st; branch_en = br; branch_target = tgt;
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        cyc(0, 0, 0, 0);
        check("bubble_after_rst", {31'b0, instr_valid}, 32'h0);
        cyc(0, 0, 0, 0);
        check("A_pc", instr_pc, 32'h0);
        check("A_instr", instr, 32'hA500_0000);
        cyc(0, 1, 0, 0);
        check("B_pc", instr_pc, 32'h4);
        check("B_instr", instr, 32'hA500_0001);
        check("count_A", fetch_count, 32'd1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("B_held_instr", instr, 32'hA500_0001);
        check("B_held_count", fetch_count, 32'd1);
        cyc(0, 0, 0, 0);
        check("B_held_pc", instr_pc, 32'h4);
        cyc(0, 0, 1, 32'h102);
        check("C_pc", instr_pc, 32'h8);
        check("C_instr", instr, 32'hA500_0002);
        cyc(0, 0, 0, 0);
        check("br_bubble", {31'b0, instr_valid}, 32'h0);
        check("br_addr", {20'b0, mem_addr}, 32'h40);
        cyc(0, 1, 1, 32'h200);
        check("br_pc", instr_pc, 32'h100);
        check("br_instr", instr, 32'hA500_0040);
        check("C_not_counted", fetch_count, 32'd2);
        cyc(0, 1, 0, 0);
        check("brst_bubble", {31'b0, instr_valid}, 32'h0);
        cyc(0, 1, 0, 0);
        check("brst_pc", instr_pc, 32'h200);
        check("brst_instr", instr, 32'hA500_0080);
        cyc(0, 0, 0, 0);
        check("brst_hold_pc", instr_pc, 32'h200);
        check("brst_hold_instr", instr, 32'hA500_0080);
        cyc(0, 0, 1, 32'h3FF8);
        check("after_rel_pc", instr_pc, 32'h204);
        check("after_rel_count", fetch_count, 32'd3);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("wrap_pc0", instr_pc, 32'h3FF8);
        cyc(0, 0, 0, 0);
        check("wrap_pc1", instr_pc, 32'h3FFC);
        check("wrap_instr1", instr, 32'hA500_0FFF);
        check("wrap_addr", {20'b0, mem_addr}, 32'h0);
        cyc(0, 1, 0, 0);
        check("wrap_pc2", instr_pc, 32'h4000);
        check("wrap_instr2", instr, 32'hA500_0000);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("midstall_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("midstall_rst_count", fetch_count, 32'h0);
        // Mixed stall/branch pattern checked against the model.
        for (int i = 0; i < 40; i++) begin
            cyc(0, (i % 5 == 2) || (i % 7 == 3), (i % 11 == 6), 32'h80 + 32'(i * 8) + 32'(i % 4));
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
